// File: rtl/div_clock_monitor.sv
// div_clock_monitor: samples a divided clock in the clk_in domain, emits edge
// strobes, measures rise-to-rise periods and declares lock after LOCK_COUNT
// consecutive in-tolerance periods. A period longer than DIV_FACTOR+TOL+1
// without a rise is a timeout and drops the monitor back to IDLE.
// Optional feature macro: DIV_MON_DUTY_EN (adds high_time output and duty check).
`timescale 1ns/1ps

module div_clock_monitor #(
  parameter int DIV_FACTOR = 4,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_clk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             err_stb
`ifdef DIV_MON_DUTY_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);

  localparam int GC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] C_DF    = CNT_W'(DIV_FACTOR);
  localparam logic [CNT_W-1:0] C_TOL   = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(DIV_FACTOR + TOL + 1);
  localparam logic [CNT_W-1:0] C_MAX   = '1;
  localparam logic [GC_W-1:0]  C_LOCK  = GC_W'(LOCK_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_s0, r_s1, r_h;
  logic              r_rise_stb, r_fall_stb, r_period_vld, r_err_stb;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_period;
  logic [GC_W-1:0]   r_good_cnt;
  logic [GC_W-1:0]   w_good_inc;
  logic              w_rise, w_fall;
  logic              w_period_ok, w_duty_ok, w_good, w_timeout;

  // Edge detection on the synchronized level versus its one-cycle history
  assign w_rise = r_s1 & ~r_h;
  assign w_fall = ~r_s1 & r_h;

  // A rise in the same cycle the limit is reached counts as a bad period, not a timeout
  assign w_timeout  = (r_state != S_IDLE) && !w_rise && (r_cnt == C_LIMIT);
  assign w_good_inc = r_good_cnt + GC_W'(1);

  assign w_period_ok = (r_cnt >= C_DF) ? ((r_cnt - C_DF) <= C_TOL)
                                       : ((C_DF - r_cnt) <= C_TOL);

`ifdef DIV_MON_DUTY_EN
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(DIV_FACTOR / 2);
  logic [CNT_W-1:0] r_high_time;

  // Capture the rise-to-fall count; the period counter restarts at 1 on each rise
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_high_time <= '0;
    end else if (w_fall) begin
      r_high_time <= r_cnt;
    end
  end

  assign w_duty_ok = (r_high_time >= C_HALF) ? ((r_high_time - C_HALF) <= C_TOL)
                                             : ((C_HALF - r_high_time) <= C_TOL);
  assign high_time = r_high_time;
`else
  assign w_duty_ok = 1'b1;
`endif

  assign w_good = w_period_ok & w_duty_ok;

  // FSM state register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_state_next = S_ACQ;
      end
      S_ACQ: begin
        if (w_rise) begin
          if (w_good && (w_good_inc == C_LOCK)) w_state_next = S_LOCKED;
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (w_rise) begin
          if (!w_good) w_state_next = S_ACQ;
        end else if (w_timeout) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs: lock indication follows the state register directly
  always_comb begin
    locked = (r_state == S_LOCKED);
  end

  // Synchronizer, strobes, period counter, measurement and error pulses
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_s0         <= 1'b0;
      r_s1         <= 1'b0;
      r_h          <= 1'b0;
      r_rise_stb   <= 1'b0;
      r_fall_stb   <= 1'b0;
      r_cnt        <= '0;
      r_period     <= '0;
      r_period_vld <= 1'b0;
      r_err_stb    <= 1'b0;
      r_good_cnt   <= '0;
    end else begin
      r_s0         <= div_clk;
      r_s1         <= r_s0;
      r_h          <= r_s1;
      r_rise_stb   <= w_rise;
      r_fall_stb   <= w_fall;
      r_period_vld <= 1'b0;
      r_err_stb    <= 1'b0;

      if (w_rise)              r_cnt <= CNT_W'(1);
      else if (r_cnt != C_MAX) r_cnt <= r_cnt + CNT_W'(1);

      if (w_rise && (r_state != S_IDLE)) begin
        r_period     <= r_cnt;
        r_period_vld <= 1'b1;
        if (!w_good) r_err_stb <= 1'b1;
      end
      if (w_timeout) r_err_stb <= 1'b1;

      if (w_rise) begin
        if ((r_state == S_IDLE) || !w_good) r_good_cnt <= '0;
        else if (r_state == S_ACQ)          r_good_cnt <= w_good_inc;
      end else if (w_timeout) begin
        r_good_cnt <= '0;
      end
    end
  end

  assign rise_stb   = r_rise_stb;
  assign fall_stb   = r_fall_stb;
  assign period     = r_period;
  assign period_vld = r_period_vld;
  assign err_stb    = r_err_stb;

endmodule
